// File: rtl/dmem_pkg.sv
// Shared types for the banked data memory: request op codes and controller states.
package dmem_pkg;

    typedef enum logic [1:0] {
        EN_IDLE  = 2'b00,
        EN_RSVD  = 2'b01,
        EN_STORE = 2'b10,
        EN_LOAD  = 2'b11
    } en_dm_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int BYTE_W = 8;

endpackage

// File: rtl/dmem_lane.sv
// One byte lane of the data memory: synchronous write port, registered read port.
module dmem_lane
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [IW-1:0]     waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              re,
    input  logic [IW-1:0]     raddr,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register only advances on a load, so the lane output holds between loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dmem_banked.sv
// Byte-lane banked data memory with a post-reset clear sweep and a
// single-cycle request port (store / load, latency-1 load data).
module dmem_banked
    import dmem_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 256,
    parameter int ADDR_LSB = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        en_dm,
    input  logic [23:0]       addr,
    input  logic [DATA_W-1:0] store_in,
    input  logic [DATA_W/8-1:0] byte_en,
    output logic [DATA_W-1:0] load_in,
    output logic              load_valid,
    output logic              err,
    output logic              init_done
);

    localparam int LANES = DATA_W / 8;
    localparam int IW    = $clog2(DEPTH);

    // One extra bit so the range check stays meaningful when DEPTH is a power of two.
    localparam logic [IW:0]   DEPTH_X  = (IW+1)'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          sweep;

    logic [IW-1:0] idx;
    logic          in_range;
    logic          accept;
    logic          op_store, op_load, op_rsvd;
    logic          store_ok, load_ok, err_d;
    logic          load_vld_p1, err_p1;
    logic          addr_unused;

    assign idx         = addr[ADDR_LSB +: IW];
    assign addr_unused = ^addr;
    assign in_range    = ({1'b0, idx} < DEPTH_X);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sweep     = 1'b0;
        req_ready = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                sweep = 1'b1;
                cnt_d = cnt_q + IW'(1);
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                req_ready = 1'b1;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign init_done = (state_q == ST_IDLE);

    assign accept   = req_valid && req_ready;
    assign op_store = accept && (en_dm == EN_STORE);
    assign op_load  = accept && (en_dm == EN_LOAD);
    assign op_rsvd  = accept && (en_dm == EN_RSVD);
    assign store_ok = op_store && in_range;
    assign load_ok  = op_load && in_range;
    assign err_d    = op_rsvd || ((op_store || op_load) && !in_range);

    // Sweep and request traffic share each lane's single write port.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic              lane_we;
        logic [IW-1:0]     lane_waddr;
        logic [BYTE_W-1:0] lane_wdata;

        assign lane_we    = sweep | (store_ok & byte_en[k]);
        assign lane_waddr = sweep ? cnt_q : idx;
        assign lane_wdata = sweep ? '0 : store_in[BYTE_W*k +: BYTE_W];

        dmem_lane #(
            .DEPTH (DEPTH),
            .IW    (IW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (lane_we),
            .waddr (lane_waddr),
            .wdata (lane_wdata),
            .re    (load_ok),
            .raddr (idx),
            .rdata (load_in[BYTE_W*k +: BYTE_W])
        );
    end

    // Stage p1: response flags line up with the registered lane read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            load_vld_p1 <= 1'b0;
            err_p1      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_vld_p1 <= load_ok;
            err_p1      <= err_d;
        end
    end

    assign load_valid = load_vld_p1;
    assign err        = err_p1;

endmodule

// File: doc/dmem_banked.md
DMEM_BANKED -- requirements
Module: dmem_banked

Interface
REQ-001 SHALL have parameter DATA_W, default 16, data width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 256, number of words; need not be a power of two.
REQ-003 SHALL have parameter ADDR_LSB, default 8, lowest addr bit of the word index; index = addr[ADDR_LSB +: $clog2(DEPTH)].
REQ-004 SHALL derive LANES = DATA_W/8 and IW = $clog2(DEPTH) as local constants.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  1  request present this cycle.
REQ-008 req_ready  out  1  block accepts a request this cycle.
REQ-009 en_dm  in  2  op code: 00 idle, 10 store, 11 load, 01 reserved.
REQ-010 addr  in  24  byte address; only the index field is used.
REQ-011 store_in  in  DATA_W  store data; lane k = store_in[8k+7:8k].
REQ-012 byte_en  in  LANES  per-lane store enable.
REQ-013 load_in  out  DATA_W  registered load data.
REQ-014 load_valid  out  1  one-cycle pulse, load_in updated.
REQ-015 err  out  1  one-cycle pulse, illegal request.
REQ-016 init_done  out  1  high once the clear sweep completes.

Function
REQ-017 SHALL use FSM states CLEAR, IDLE; reset enters CLEAR with sweep counter 0.
REQ-018 CLEAR: one word per cycle zeroed in all lanes, counter 0..DEPTH-1; req_ready=0; after word DEPTH-1 go to IDLE and set init_done=1 (DEPTH cycles total).
REQ-019 IDLE: req_ready=1; a request is accepted when req_valid && req_ready.
REQ-020 Accepted store (10): each lane with byte_en[k]=1 writes store_in lane k at index on that edge; lanes with byte_en[k]=0 unchanged; byte_en=0 is a legal no-op.
REQ-021 Accepted load (11): load_in = all lanes at index, registered; load_valid pulses in the cycle after acceptance (latency 1).
REQ-022 load_in SHALL hold its value between loads; no load_valid for stores, idle or errors.
REQ-023 Store then load to same index on the next cycle SHALL return the newly stored data.
REQ-024 Back-to-back loads SHALL be accepted every cycle, one load_valid per load.
REQ-025 Index >= DEPTH on store or load: no write, load_in unchanged, no load_valid, err pulses next cycle.
REQ-026 en_dm=01 accepted: no memory effect, err pulses next cycle.
REQ-027 en_dm=00 with req_valid: no effect, no err.
REQ-028 Requests with req_valid=1 during CLEAR are not accepted and have no effect.

Reset
REQ-029 rst_n low SHALL immediately force: load_in=0, load_valid=0, err=0, init_done=0, req_ready=0, state CLEAR, counter 0.
REQ-030 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from index 0; memory contents are not asynchronously cleared.

Structure
REQ-031 Package dmem_pkg SHALL hold en_dm codes (EN_IDLE, EN_RSVD, EN_STORE, EN_LOAD) and the FSM state type.
REQ-032 Sub-module dmem_lane (8-bit x DEPTH, synchronous write with enable, registered read) SHALL be instantiated LANES times by generate.
REQ-033 Sweep writes and request writes SHALL share one lane write port, muxed by state.

Verification
REQ-034 Reset release, DATA_W=16, DEPTH=256 -> req_ready low 256 cycles, then init_done=1; load index 0 -> load_in=16'h0000.
REQ-035 Store addr=24'h000300, store_in=16'hA5C3, byte_en=2'b11, next cycle load same -> load_valid next cycle, load_in=16'hA5C3.
REQ-036 Store 16'hFFFF index 5, then store 16'h1200 byte_en=2'b10 index 5, load -> load_in=16'h12FF.
REQ-037 DEPTH=200, load index 200 -> err pulse, no load_valid, load_in unchanged; en_dm=01 -> err pulse.
REQ-038 Loads to indices 1,2,3 on consecutive cycles -> three consecutive load_valid pulses with matching data.
REQ-039 rst_n low at sweep count 100, release -> full 256-cycle sweep again before req_ready=1.
